// File: rtl/chip_shiftreg_checker_if.sv
// rtl/chip_shiftreg_checker_if.sv - Run/Done handshake, result and DUT pin bundle for the 74194 checker
// master is the checker's view, slave is the chip-checker top level / socket side.
interface chip_shiftreg_checker_if #(
  parameter int WIDTH = 4
);
  logic             Run;
  logic             DISP_RSLT;
  logic [WIDTH-1:0] DUT_Q;
  logic             DUT_CLK;
  logic             DUT_CLR_n;
  logic [1:0]       DUT_S;
  logic             DUT_SR;
  logic             DUT_SL;
  logic [WIDTH-1:0] DUT_D;
  logic             Done;
  logic             RSLT;
  logic [15:0]      Fail_count;
  logic [15:0]      First_fail;
  logic             Fail_valid;

  modport master (
    input  Run, DISP_RSLT, DUT_Q,
    output DUT_CLK, DUT_CLR_n, DUT_S, DUT_SR, DUT_SL, DUT_D,
           Done, RSLT, Fail_count, First_fail, Fail_valid
  );

  modport slave (
    output Run, DISP_RSLT, DUT_Q,
    input  DUT_CLK, DUT_CLR_n, DUT_S, DUT_SR, DUT_SL, DUT_D,
           Done, RSLT, Fail_count, First_fail, Fail_valid
  );
endinterface

// File: rtl/chip_shiftreg_checker.sv
// rtl/chip_shiftreg_checker.sv - 74194-family universal shift register tester with golden model
// Exhaustive vector counter by default; define CHK_LFSR_EN for NUM_VECTORS LFSR vectors.
module chip_shiftreg_checker #(
  parameter int          WIDTH       = 4,
  parameter int          SETTLE      = 2,
  parameter int          NUM_VECTORS = 1024,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  Clk,
  input  logic                  Reset,
  chip_shiftreg_checker_if.master bus
);

  localparam int VW = WIDTH + 5;
  localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
`ifdef CHK_LFSR_EN
  localparam logic [15:0] LAST_IDX = 16'(NUM_VECTORS - 1);
`else
  localparam logic [15:0] LAST_IDX = 16'((1 << VW) - 1);
`endif

  if (WIDTH < 2 || WIDTH > 8 || SETTLE < 1 || NUM_VECTORS < 1 || NUM_VECTORS > 65535 ||
      LFSR_SEED == 16'h0000) begin : g_bad_cfg
    $error("chip_shiftreg_checker: parameter out of range");
  end

  typedef enum logic [2:0] {HALTED, INIT, DRIVE, PULSE, CHECK, DONE_S} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      idx_q, idx_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic             rslt_q, rslt_d;
  logic [15:0]      fc_q, fc_d;
  logic [15:0]      ff_q, ff_d;
  logic             fv_q, fv_d;

  logic             dclk_q, dclk_d;
  logic             clr_q, clr_d;
  logic [1:0]       s_q, s_d;
  logic             sr_q, sr_d;
  logic             sl_q, sl_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             done_q, done_d;

  logic [VW-1:0]    vec_cur, vec_nxt;
  logic             phase_end;

`ifdef CHK_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  assign vec_cur = lfsr_q[VW-1:0];
  assign vec_nxt = lfsr_d[VW-1:0];
`else
  assign vec_cur = idx_q[VW-1:0];
  assign vec_nxt = idx_d[VW-1:0];
`endif

  assign phase_end = (cnt_q == CW'(SETTLE - 1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    m_d     = m_q;
    rslt_d  = rslt_q;
    fc_d    = fc_q;
    ff_d    = ff_q;
    fv_d    = fv_q;
`ifdef CHK_LFSR_EN
    lfsr_d  = lfsr_q;
`endif
    case (state_q)
      HALTED: begin
        if (bus.Run) begin
          state_d = INIT;
          cnt_d   = '0;
          idx_d   = '0;
          m_d     = '0;
          rslt_d  = 1'b1;
          fc_d    = '0;
          ff_d    = '0;
          fv_d    = 1'b0;
`ifdef CHK_LFSR_EN
          lfsr_d  = LFSR_SEED;
`endif
        end
      end
      INIT, PULSE: begin
        if (phase_end) begin
          state_d = (state_q == INIT) ? DRIVE : CHECK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DRIVE: begin
        if (phase_end) begin
          state_d = PULSE;
          cnt_d   = '0;
          // Golden model steps here so it is ready before the DUT clock rises.
          if (!vec_cur[WIDTH+2]) begin
            m_d = '0;
          end else begin
            case (vec_cur[WIDTH+1:WIDTH])
              2'b11:   m_d = vec_cur[WIDTH-1:0];
              2'b01:   m_d = {vec_cur[WIDTH+3], m_q[WIDTH-1:1]};
              2'b10:   m_d = {m_q[WIDTH-2:0], vec_cur[WIDTH+4]};
              default: m_d = m_q;
            endcase
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      CHECK: begin
        if (bus.DUT_Q != m_q) begin
          rslt_d = 1'b0;
          if (fc_q != 16'hFFFF) fc_d = fc_q + 16'd1;
          if (!fv_q) ff_d = idx_q;
          fv_d = 1'b1;
        end
`ifdef CHK_LFSR_EN
        lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
`endif
        if (idx_q == LAST_IDX) begin
          state_d = DONE_S;
        end else begin
          idx_d   = idx_q + 16'd1;
          state_d = DRIVE;
        end
      end
      DONE_S: begin
        if (bus.DISP_RSLT) state_d = HALTED;
      end
      default: state_d = HALTED;
    endcase
  end

  // Pins are decoded from the next state so every output leaves a flop.
  always_comb begin
    dclk_d = 1'b0;
    clr_d  = 1'b0;
    s_d    = 2'b00;
    sr_d   = 1'b0;
    sl_d   = 1'b0;
    d_d    = '0;
    done_d = 1'b0;
    case (state_d)
      DRIVE, PULSE, CHECK: begin
        dclk_d = (state_d == PULSE);
        clr_d  = vec_nxt[WIDTH+2];
        s_d    = vec_nxt[WIDTH+1:WIDTH];
        sr_d   = vec_nxt[WIDTH+3];
        sl_d   = vec_nxt[WIDTH+4];
        d_d    = vec_nxt[WIDTH-1:0];
      end
      DONE_S:  done_d = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= HALTED;
      cnt_q   <= '0;
      idx_q   <= '0;
      m_q     <= '0;
      rslt_q  <= 1'b0;
      fc_q    <= '0;
      ff_q    <= '0;
      fv_q    <= 1'b0;
      dclk_q  <= 1'b0;
      clr_q   <= 1'b0;
      s_q     <= 2'b00;
      sr_q    <= 1'b0;
      sl_q    <= 1'b0;
      d_q     <= '0;
      done_q  <= 1'b0;
`ifdef CHK_LFSR_EN
      lfsr_q  <= LFSR_SEED;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      m_q     <= m_d;
      rslt_q  <= rslt_d;
      fc_q    <= fc_d;
      ff_q    <= ff_d;
      fv_q    <= fv_d;
      dclk_q  <= dclk_d;
      clr_q   <= clr_d;
      s_q     <= s_d;
      sr_q    <= sr_d;
      sl_q    <= sl_d;
      d_q     <= d_d;
      done_q  <= done_d;
`ifdef CHK_LFSR_EN
      lfsr_q  <= lfsr_d;
`endif
    end
  end

  assign bus.DUT_CLK    = dclk_q;
  assign bus.DUT_CLR_n  = clr_q;
  assign bus.DUT_S      = s_q;
  assign bus.DUT_SR     = sr_q;
  assign bus.DUT_SL     = sl_q;
  assign bus.DUT_D      = d_q;
  assign bus.Done       = done_q;
  assign bus.RSLT       = rslt_q;
  assign bus.Fail_count = fc_q;
  assign bus.First_fail = ff_q;
  assign bus.Fail_valid = fv_q;

endmodule

// File: tb/tb_chip_shiftreg_checker.sv
// tb/tb_chip_shiftreg_checker.sv - checker driving a behavioural 74194 with injectable faults
module tb_chip_shiftreg_checker;
  localparam int          W    = 4;
  localparam int          S    = 2;
  localparam int          NVEC = 1024;
  localparam logic [15:0] SEED = 16'hACE1;
  localparam int          VW   = W + 5;
  localparam int          MASK = (1 << W) - 1;
`ifdef CHK_LFSR_EN
  localparam int NV = NVEC;
`else
  localparam int NV = 1 << VW;
`endif
  localparam int RUN_CYC = S + NV * (2 * S + 1);

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  chip_shiftreg_checker_if #(.WIDTH(W)) bus();

  chip_shiftreg_checker #(
    .WIDTH(W), .SETTLE(S), .NUM_VECTORS(NVEC), .LFSR_SEED(SEED)
  ) dut (
    .Clk(clk), .Reset(rst_n), .bus(bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Socket chip: 0 ideal, 1 output bit stuck, 2 SR/SL swapped, 3 outputs inverted
  int fault_mode = 0;
  int fault_bit  = 0;
  int fault_val  = 0;
  logic [W-1:0] chip_q = '0;
  logic [W-1:0] obs_q;

  always @(posedge bus.DUT_CLK or negedge bus.DUT_CLR_n) begin
    if (!bus.DUT_CLR_n) chip_q <= '0;
    else begin
      case (bus.DUT_S)
        2'b11: chip_q <= bus.DUT_D;
        2'b01: chip_q <= {(fault_mode == 2) ? bus.DUT_SL : bus.DUT_SR, chip_q[W-1:1]};
        2'b10: chip_q <= {chip_q[W-2:0], (fault_mode == 2) ? bus.DUT_SR : bus.DUT_SL};
        default: ;
      endcase
    end
  end

  always_comb begin
    obs_q = chip_q;
    if (fault_mode == 1) obs_q[fault_bit] = fault_val[0];
    else if (fault_mode == 3) obs_q = ~chip_q;
  end
  assign bus.DUT_Q = obs_q;

  function automatic int vec_of(input int k);
`ifdef CHK_LFSR_EN
    int l = SEED;
    for (int i = 0; i < k; i++) l = (l >> 1) | ((((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1) << 15);
    return l & ((1 << VW) - 1);
`else
    return k;
`endif
  endfunction

  function automatic int step(input int r, input int v, input int sr, input int sl);
    if (((v >> (W + 2)) & 1) == 0) return 0;
    case ((v >> W) & 3)
      3: return v & MASK;
      1: return (sr << (W - 1)) | (r >> 1);
      2: return ((r << 1) | sl) & MASK;
      default: return r;
    endcase
  endfunction

  // Whole-test expectation: walk all vectors, compare ideal register vs what the faulty socket shows.
  task automatic ref_run(input int mode, input int fb, input int fv, output int cnt, output int first);
    int m = 0, c = 0, obs, v, sr, sl;
    cnt = 0;
    first = -1;
    for (int k = 0; k < NV; k++) begin
      v  = vec_of(k);
      sr = (v >> (W + 3)) & 1;
      sl = (v >> (W + 4)) & 1;
      m  = step(m, v, sr, sl);
      c  = (mode == 2) ? step(c, v, sl, sr) : step(c, v, sr, sl);
      if (mode == 1) obs = fv ? (c | (1 << fb)) : (c & ~(1 << fb));
      else if (mode == 3) obs = ~c & MASK;
      else obs = c;
      if (obs != m) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
  endtask

  task automatic run_test(input bit hold, output int cycles);
    @(negedge clk);
    bus.Run = 1'b1;
    @(posedge clk);
    if (!hold) #1 bus.Run = 1'b0;
    cycles = 0;
    while (1) begin
      @(negedge clk);
      if (bus.Done) break;
      if (cycles > RUN_CYC + 100) break;
      @(posedge clk);
      cycles++;
    end
    check_eq("done_timeout", {31'd0, bus.Done}, 32'd1);
  endtask

  task automatic ack();
    @(negedge clk);
    bus.DISP_RSLT = 1'b1;
    @(negedge clk);
    bus.DISP_RSLT = 1'b0;
  endtask

  task automatic full_check(input string tag, input int mode, input int fb, input int fv);
    int cnt, first, cyc;
    fault_mode = mode;
    fault_bit  = fb;
    fault_val  = fv;
    ref_run(mode, fb, fv, cnt, first);
    repeat ($urandom_range(0, 5)) @(negedge clk);
    run_test(1'b0, cyc);
    check_eq({tag, "_cycles"}, cyc, RUN_CYC);
    check_eq({tag, "_rslt"}, {31'd0, bus.RSLT}, (cnt == 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_fcount"}, {16'd0, bus.Fail_count}, (cnt > 65535) ? 32'd65535 : cnt);
    check_eq({tag, "_fvalid"}, {31'd0, bus.Fail_valid}, (cnt != 0) ? 32'd1 : 32'd0);
    check_eq({tag, "_ffirst"}, {16'd0, bus.First_fail}, (cnt != 0) ? first : 32'd0);
    ack();
    check_eq({tag, "_done_clr"}, {31'd0, bus.Done}, 32'd0);
    check_eq({tag, "_rslt_hold"}, {31'd0, bus.RSLT}, (cnt == 0) ? 32'd1 : 32'd0);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_done"}, {31'd0, bus.Done}, 32'd0);
    check_eq({tag, "_rslt"}, {31'd0, bus.RSLT}, 32'd0);
    check_eq({tag, "_fcount"}, {16'd0, bus.Fail_count}, 32'd0);
    check_eq({tag, "_ffirst"}, {16'd0, bus.First_fail}, 32'd0);
    check_eq({tag, "_fvalid"}, {31'd0, bus.Fail_valid}, 32'd0);
    check_eq({tag, "_pins"}, {17'd0, bus.DUT_CLK, bus.DUT_CLR_n, bus.DUT_S, bus.DUT_SR,
                              bus.DUT_SL, 4'(bus.DUT_D), 4'd0}, 32'd0);
  endtask

  initial begin
    int cyc, v40, hi;
    bus.Run       = 1'b0;
    bus.DISP_RSLT = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst_n = 1'b1;

    full_check("ideal", 0, 0, 0);
    full_check("stuck0", 1, 0, 0);
`ifndef CHK_LFSR_EN
    check_eq("stuck0_first113", {16'd0, bus.First_fail}, 32'd113);
`endif
    for (int i = 0; i < 3; i++)
      full_check("rstuck", 1, $urandom_range(0, W - 1), $urandom_range(0, 1));
    full_check("swap", 2, 0, 0);
    full_check("invert", 3, 0, 0);
    check_eq("invert_all", {16'd0, bus.Fail_count}, NV);

    // Abort during the Pulse phase of vector 40
    fault_mode = 0;
    v40 = vec_of(40);
    @(negedge clk);
    bus.Run = 1'b1;
    @(posedge clk);
    #1 bus.Run = 1'b0;
    repeat (S + 40 * (2 * S + 1) + S) @(posedge clk);
    #2;
    check_eq("abort_clk", {31'd0, bus.DUT_CLK}, 32'd1);
    check_eq("abort_d", {28'd0, 4'(bus.DUT_D)}, v40 & MASK);
    check_eq("abort_s", {30'd0, bus.DUT_S}, (v40 >> W) & 3);
    check_eq("abort_rslt_pre", {31'd0, bus.RSLT}, 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("abort");
    @(negedge clk);
    rst_n = 1'b1;
    full_check("after_rst", 0, 0, 0);

    // Run held high: one test only, Done sticks until acknowledged
    run_test(1'b1, cyc);
    check_eq("hold_cycles", cyc, RUN_CYC);
    hi = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.Done) hi++;
    end
    check_eq("hold_done_sticks", hi, 20);
    bus.Run = 1'b0;
    ack();
    check_eq("hold_done_clr", {31'd0, bus.Done}, 32'd0);
    check_eq("hold_rslt", {31'd0, bus.RSLT}, 32'd1);
    repeat (10) @(negedge clk);
    check_eq("hold_no_restart", {31'd0, bus.DUT_CLR_n | bus.DUT_CLK | bus.Done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
